// File: rtl/periph_pkg.sv
// Shared definitions for the peripheral receive path: data width, default
// sizing and the receive FSM state encoding.
package periph_pkg;

   localparam int DATA_W        = 32;
   localparam int DEFAULT_DEPTH = 4;
   localparam int DEFAULT_CNT_W = 16;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } rx_state_e;

endpackage : periph_pkg

// File: rtl/periph_fifo.sv
// Receive buffer: DEPTH x DATA_W strict FIFO with push/pop and full/empty.
// The head word reads as zero while the buffer is empty.
module periph_fifo
   import periph_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic              clk_per,
   input  logic              rst_per,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    used;
   logic              do_push;
   logic              do_pop;

   // A pop frees a slot in the same edge, so a full buffer can still take a push.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign empty = (used == '0);
   assign full  = (used == (PTR_W+1)'(DEPTH));
   assign head  = empty ? '0 : mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk_per or negedge rst_per) begin
      if (!rst_per) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         used   <= '0;
      end else begin
         // DEPTH is a power of two, so pointer overflow is the modulo wrap.
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         used <= used + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      end
   end

   // NOTE: storage is deliberately not reset; the empty flag masks stale
   // contents, and leaving it out keeps the array mappable to plain flops/RAM.
   always_ff @(posedge clk_per) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule : periph_fifo

// File: rtl/fsm_periph_rx.sv
// Strobe-driven receive peripheral: one word per rising strobe into a FIFO,
// with an accept pulse, a sticky overflow flag and a wrapping accept counter.
module fsm_periph_rx
   import periph_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic              clk_per,
   input  logic              rst_per,
   input  logic              inSEND_per,
   input  logic [DATA_W-1:0] inDATA_per,
   input  logic              inREAD_per,
   output logic [DATA_W-1:0] outDATA_per,
   output logic              outVALID_per,
   output logic              outACK_per,
   output logic              outOVF_per,
   output logic [CNT_W-1:0]  outCOUNT_per
);

   rx_state_e state;
   logic      fifo_full;
   logic      fifo_empty;
   logic      pop;
   logic      capture;
   logic      store;
   logic      drop;

   // A held strobe is a single word: only the IDLE->BUSY transition captures.
   assign capture = (state == IDLE) && inSEND_per;
   assign pop     = inREAD_per && !fifo_empty;
   assign store   = capture && (!fifo_full || pop);
   assign drop    = capture && !store;

   periph_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_per (clk_per),
      .rst_per (rst_per),
      .push    (store),
      .pop     (pop),
      .wdata   (inDATA_per),
      .head    (outDATA_per),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign outVALID_per = !fifo_empty;

   always_ff @(posedge clk_per or negedge rst_per) begin
      if (!rst_per) begin
         state        <= IDLE;
         outACK_per   <= 1'b0;
         outOVF_per   <= 1'b0;
         outCOUNT_per <= '0;
      end else begin
         case (state)
            IDLE:    if (inSEND_per)  state <= BUSY;
            BUSY:    if (!inSEND_per) state <= IDLE;
            default: state <= IDLE;
         endcase
         outACK_per <= store;
         if (drop)  outOVF_per   <= 1'b1;
         if (store) outCOUNT_per <= outCOUNT_per + 1'b1;
      end
   end

endmodule : fsm_periph_rx

// File: tb/tb_fsm_periph_rx.sv
// Self-checking bench for fsm_periph_rx: directed scenarios plus random
// traffic against a queue-based model of the receive rules.
module tb_fsm_periph_rx;

   localparam int DEPTH_TB = 4;
   localparam int CNT_W_TB = 10;

   logic                clk_per = 1'b0;
   logic                rst_per;
   logic                inSEND_per;
   logic [31:0]         inDATA_per;
   logic                inREAD_per;
   logic [31:0]         outDATA_per;
   logic                outVALID_per;
   logic                outACK_per;
   logic                outOVF_per;
   logic [CNT_W_TB-1:0] outCOUNT_per;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a word is accepted on each low-to-high strobe change.
   logic [31:0]         m_q[$];
   bit                  m_prev;
   bit                  m_ack;
   bit                  m_ovf;
   logic [CNT_W_TB-1:0] m_cnt;

   fsm_periph_rx #(
      .DEPTH (DEPTH_TB),
      .CNT_W (CNT_W_TB)
   ) dut (
      .clk_per      (clk_per),
      .rst_per      (rst_per),
      .inSEND_per   (inSEND_per),
      .inDATA_per   (inDATA_per),
      .inREAD_per   (inREAD_per),
      .outDATA_per  (outDATA_per),
      .outVALID_per (outVALID_per),
      .outACK_per   (outACK_per),
      .outOVF_per   (outOVF_per),
      .outCOUNT_per (outCOUNT_per)
   );

   always #5 clk_per = ~clk_per;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void model_reset();
      m_q.delete();
      m_prev = 1'b0;
      m_ack  = 1'b0;
      m_ovf  = 1'b0;
      m_cnt  = '0;
   endfunction

   function automatic void model_edge(bit send, logic [31:0] data, bit rd);
      bit accept;
      accept = send && !m_prev;
      if (rd && m_q.size() > 0) void'(m_q.pop_front());
      m_ack = 1'b0;
      if (accept) begin
         if (m_q.size() < DEPTH_TB) begin
            m_q.push_back(data);
            m_ack = 1'b1;
            m_cnt = m_cnt + 1'b1;
         end else begin
            m_ovf = 1'b1;
         end
      end
      m_prev = send;
   endfunction

   function automatic logic [31:0] m_head();
      return (m_q.size() > 0) ? m_q[0] : 32'h0;
   endfunction

   task automatic step(input bit send, input logic [31:0] data, input bit rd);
      inSEND_per = send;
      inDATA_per = data;
      inREAD_per = rd;
      @(posedge clk_per);
      model_edge(send, data, rd);
      #1;
   endtask

   task automatic do_reset();
      rst_per = 1'b0;
      #1;
      model_reset();
      @(negedge clk_per);
      rst_per = 1'b1;
   endtask

   task automatic test_reset();
      inSEND_per = 1'b0;
      inDATA_per = '0;
      inREAD_per = 1'b0;
      do_reset();
      n_tests++; if (outVALID_per !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", outVALID_per); end
      n_tests++; if (outDATA_per !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", outDATA_per); end
      n_tests++; if (outACK_per !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0", outACK_per); end
      n_tests++; if (outOVF_per !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", outOVF_per); end
      n_tests++; if (outCOUNT_per !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", outCOUNT_per); end
   endtask

   task automatic test_alternate();
      int acks = 0;
      do_reset();
      step(1'b1, 32'hDEADBEEF, 1'b0); acks += int'(outACK_per);
      step(1'b0, 32'h0, 1'b0);        acks += int'(outACK_per);
      step(1'b1, 32'h12345678, 1'b0); acks += int'(outACK_per);
      step(1'b0, 32'h0, 1'b0);        acks += int'(outACK_per);
      n_tests++; if (outDATA_per !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alt_head got=%h exp=deadbeef", outDATA_per); end
      n_tests++; if (acks != 2) begin n_fail++; $display("FAIL alt_acks got=%0d exp=2", acks); end
      n_tests++; if (outCOUNT_per !== CNT_W_TB'(2)) begin n_fail++; $display("FAIL alt_count got=%0d exp=2", outCOUNT_per); end
   endtask

   task automatic test_held_strobe();
      int acks = 0;
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         step(1'b1, 32'(i), 1'b0);
         acks += int'(outACK_per);
      end
      step(1'b0, 32'h0, 1'b0); acks += int'(outACK_per);
      n_tests++; if (acks != 1) begin n_fail++; $display("FAIL held_acks got=%0d exp=1", acks); end
      n_tests++; if (outCOUNT_per !== CNT_W_TB'(1)) begin n_fail++; $display("FAIL held_count got=%0d exp=1", outCOUNT_per); end
      n_tests++; if (outDATA_per !== 32'h1) begin n_fail++; $display("FAIL held_head got=%h exp=1", outDATA_per); end
      step(1'b0, 32'h0, 1'b1);
      n_tests++; if (outVALID_per !== 1'b0) begin n_fail++; $display("FAIL held_single_word valid got=%b exp=0", outVALID_per); end
   endtask

   task automatic test_empty_read();
      do_reset();
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      n_tests++; if (outVALID_per !== 1'b0) begin n_fail++; $display("FAIL empty_read_valid got=%b exp=0", outVALID_per); end
      step(1'b1, 32'h00000077, 1'b1);
      n_tests++; if (outVALID_per !== 1'b1 || outDATA_per !== 32'h77) begin n_fail++; $display("FAIL empty_capture got=%b/%h exp=1/00000077", outVALID_per, outDATA_per); end
      n_tests++; if (outACK_per !== 1'b1) begin n_fail++; $display("FAIL empty_capture_ack got=%b exp=1", outACK_per); end
   endtask

   task automatic test_overflow_and_full_read();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 32'h100 + 32'(i), 1'b0);
         if (i == 3) begin
            n_tests++; if (outOVF_per !== 1'b0) begin n_fail++; $display("FAIL ovf_early got=%b exp=0", outOVF_per); end
         end
         if (i == 4) begin
            n_tests++; if (outOVF_per !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", outOVF_per); end
            n_tests++; if (outACK_per !== 1'b0) begin n_fail++; $display("FAIL ovf_ack got=%b exp=0", outACK_per); end
         end
         step(1'b0, 32'h0, 1'b0);
      end
      n_tests++; if (outCOUNT_per !== CNT_W_TB'(4)) begin n_fail++; $display("FAIL ovf_count got=%0d exp=4", outCOUNT_per); end
      n_tests++; if (outDATA_per !== 32'h100) begin n_fail++; $display("FAIL ovf_head got=%h exp=00000100", outDATA_per); end
      // Full buffer, pop and capture on the same edge.
      step(1'b1, 32'hA5A5A5A5, 1'b1);
      n_tests++; if (outACK_per !== 1'b1) begin n_fail++; $display("FAIL fullrd_ack got=%b exp=1", outACK_per); end
      n_tests++; if (outCOUNT_per !== CNT_W_TB'(5)) begin n_fail++; $display("FAIL fullrd_count got=%0d exp=5", outCOUNT_per); end
      n_tests++; if (outDATA_per !== 32'h101) begin n_fail++; $display("FAIL fullrd_head got=%h exp=00000101", outDATA_per); end
      step(1'b0, 32'h0, 1'b0);
      for (int i = 0; i < DEPTH_TB; i++) begin
         n_tests++; if (outDATA_per !== m_head() || outVALID_per !== 1'b1) begin n_fail++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, outVALID_per, outDATA_per, m_head()); end
         if (i == DEPTH_TB - 1) begin
            n_tests++; if (outDATA_per !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL fullrd_tail got=%h exp=a5a5a5a5", outDATA_per); end
         end
         step(1'b0, 32'h0, 1'b1);
      end
      n_tests++; if (outVALID_per !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%b exp=0", outVALID_per); end
   endtask

   task automatic test_reset_mid_transfer();
      do_reset();
      step(1'b1, 32'hAAAA0001, 1'b0);
      step(1'b0, 32'h0, 1'b0);
      step(1'b1, 32'hAAAA0002, 1'b0);
      step(1'b0, 32'h0, 1'b0);
      step(1'b1, 32'hAAAA0003, 1'b0);
      step(1'b1, 32'hAAAA0003, 1'b0);
      inSEND_per = 1'b1;
      inDATA_per = 32'h00000042;
      rst_per    = 1'b0;
      #1;
      model_reset();
      n_tests++; if ({outVALID_per, outACK_per, outOVF_per} !== 3'b000 || outDATA_per !== 32'h0 || outCOUNT_per !== '0) begin
         n_fail++; $display("FAIL midrst_outputs got v=%b a=%b o=%b d=%h c=%0d exp all 0", outVALID_per, outACK_per, outOVF_per, outDATA_per, outCOUNT_per);
      end
      @(negedge clk_per);
      rst_per = 1'b1;
      step(1'b1, 32'h00000042, 1'b0);
      n_tests++; if (outDATA_per !== 32'h42 || outVALID_per !== 1'b1) begin n_fail++; $display("FAIL midrst_capture got=%b/%h exp=1/00000042", outVALID_per, outDATA_per); end
      n_tests++; if (outCOUNT_per !== CNT_W_TB'(1)) begin n_fail++; $display("FAIL midrst_count got=%0d exp=1", outCOUNT_per); end
   endtask

   task automatic test_random();
      bit          send;
      bit          rd;
      logic [31:0] data;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         send = ($urandom_range(0, 2) != 0);
         rd   = (i < 200) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
         data = $urandom;
         step(send, data, rd);
         n_tests++;
         if (outVALID_per !== (m_q.size() > 0) || outDATA_per !== m_head() || outACK_per !== m_ack
             || outOVF_per !== m_ovf || outCOUNT_per !== m_cnt) begin
            n_fail++;
            $display("FAIL rand_%0d got v=%b d=%h a=%b o=%b c=%0d exp v=%b d=%h a=%b o=%b c=%0d", i,
                     outVALID_per, outDATA_per, outACK_per, outOVF_per, outCOUNT_per,
                     m_q.size() > 0, m_head(), m_ack, m_ovf, m_cnt);
         end
      end
   endtask

   task automatic test_count_wrap();
      int n_words = 1 << CNT_W_TB;
      do_reset();
      for (int i = 0; i < n_words - 1; i++) begin
         step(1'b1, 32'(i), 1'b1);
         step(1'b0, 32'h0, 1'b1);
      end
      n_tests++; if (outCOUNT_per !== {CNT_W_TB{1'b1}}) begin n_fail++; $display("FAIL wrap_allones got=%0d exp=%0d", outCOUNT_per, n_words - 1); end
      step(1'b1, 32'hFFFF0000, 1'b1);
      n_tests++; if (outCOUNT_per !== '0) begin n_fail++; $display("FAIL wrap_zero got=%0d exp=0", outCOUNT_per); end
      n_tests++; if (outOVF_per !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf got=%b exp=0", outOVF_per); end
      n_tests++; if (outCOUNT_per !== m_cnt) begin n_fail++; $display("FAIL wrap_model got=%0d exp=%0d", outCOUNT_per, m_cnt); end
   endtask

   initial begin
      rst_per    = 1'b0;
      inSEND_per = 1'b0;
      inDATA_per = '0;
      inREAD_per = 1'b0;
      model_reset();
      test_reset();
      test_alternate();
      test_held_strobe();
      test_empty_read();
      test_overflow_and_full_read();
      test_reset_mid_transfer();
      test_random();
      test_count_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_fsm_periph_rx
